pkt_rr_arbiter: RTL



---
 rtl/pkt_arb_pkg.sv | 19 +
 rtl/pkt_rr_arbiter_rr_pick.sv | 29 ++
 rtl/pkt_rr_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pkt_arb_pkg.sv
// rtl/pkt_arb_pkg.sv - shared state encoding, counter width and slice helper for the packet arbiter
package pkt_arb_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SEND = 1'b1;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_SEND = ST_SEND
  } arb_state_t;

  localparam int PKT_CNT_W = 32;

  // Low bit of slice idx inside a flattened per-queue bus.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/pkt_rr_arbiter_rr_pick.sv
// rtl/pkt_rr_arbiter_rr_pick.sv - combinational rotating-priority picker, searching from base+1 upward
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  output logic          found,
  output logic [IW-1:0] idx
);

  function automatic logic [IW-1:0] rot(input logic [IW-1:0] b, input int k);
    int s;
    s = (int'(b) + 1 + k) % N;
    return IW'(s);
  endfunction

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[rot(base, k)]) begin
        found = 1'b1;
        idx   = rot(base, k);
      end
    end
  end

endmodule

// File: rtl/pkt_rr_arbiter.sv
// rtl/pkt_rr_arbiter.sv - packet-granular round-robin merge of fall-through FIFOs onto one AXI4-Stream master
// Optional per-queue packet counters enabled by defining PKT_ARB_CNT_EN.
module pkt_rr_arbiter
  import pkt_arb_pkg::*;
#(
  parameter int NUM_QUEUES           = 4,
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128
) (
  input  logic                                         axis_aclk,
  input  logic                                         axis_reset,
  input  logic [NUM_QUEUES-1:0]                        i_fifo_empty,
  output logic [NUM_QUEUES-1:0]                        o_fifo_rd_en,
  input  logic [NUM_QUEUES*C_M_AXIS_DATA_WIDTH-1:0]    i_tdata_fifo,
  input  logic [NUM_QUEUES*C_M_AXIS_TUSER_WIDTH-1:0]   i_tuser_fifo,
  input  logic [NUM_QUEUES*C_M_AXIS_DATA_WIDTH/8-1:0]  i_tkeep_fifo,
  input  logic [NUM_QUEUES-1:0]                        i_tlast_fifo,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]               m_axis_tdata,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]              m_axis_tuser,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]             m_axis_tkeep,
  output logic                                         m_axis_tlast,
  output logic                                         m_axis_tvalid,
  input  logic                                         m_axis_tready,
  output logic [NUM_QUEUES-1:0]                        o_grant,
  output logic [NUM_QUEUES*PKT_CNT_W-1:0]              o_pkt_cnt
);

  localparam int DW = C_M_AXIS_DATA_WIDTH;
  localparam int UW = C_M_AXIS_TUSER_WIDTH;
  localparam int KW = C_M_AXIS_DATA_WIDTH / 8;
  localparam int IW = $clog2(NUM_QUEUES);

  arb_state_t    state, state_nxt;
  logic [IW-1:0] sel, sel_nxt;
  logic [IW-1:0] last_grant, last_grant_nxt;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [NUM_QUEUES-1:0] req;
  logic          pkt_done;

  logic [DW-1:0] sel_tdata;
  logic [UW-1:0] sel_tuser;
  logic [KW-1:0] sel_tkeep;
  logic          sel_tlast;
  logic          sel_empty;

  assign req = ~i_fifo_empty;

  rr_pick #(
    .N  (NUM_QUEUES),
    .IW (IW)
  ) u_rr_pick (
    .req   (req),
    .base  (last_grant),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    sel_tdata = '0;
    sel_tuser = '0;
    sel_tkeep = '0;
    sel_tlast = 1'b0;
    sel_empty = 1'b1;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      if (sel == IW'(q)) begin
        sel_tdata = i_tdata_fifo[slice_lo(q, DW) +: DW];
        sel_tuser = i_tuser_fifo[slice_lo(q, UW) +: UW];
        sel_tkeep = i_tkeep_fifo[slice_lo(q, KW) +: KW];
        sel_tlast = i_tlast_fifo[q];
        sel_empty = i_fifo_empty[q];
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    sel_nxt        = sel;
    last_grant_nxt = last_grant;
    pkt_done       = 1'b0;
    m_axis_tvalid  = 1'b0;
    m_axis_tdata   = '0;
    m_axis_tuser   = '0;
    m_axis_tkeep   = '0;
    m_axis_tlast   = 1'b0;
    o_fifo_rd_en   = '0;
    o_grant        = '0;
    unique case (state)
      S_IDLE: begin
        if (pick_found) begin
          state_nxt      = S_SEND;
          sel_nxt        = pick_idx;
          last_grant_nxt = pick_idx;
        end
      end
      S_SEND: begin
        o_grant[sel]  = 1'b1;
        m_axis_tvalid = !sel_empty;
        if (!sel_empty) begin
          m_axis_tdata = sel_tdata;
          m_axis_tuser = sel_tuser;
          m_axis_tkeep = sel_tkeep;
          m_axis_tlast = sel_tlast;
          if (m_axis_tready) begin
            o_fifo_rd_en[sel] = 1'b1;
            if (sel_tlast) begin
              state_nxt = S_IDLE;
              pkt_done  = 1'b1;
            end
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Reset abandons an in-flight packet without popping, so leftover beats stay queued.
    if (axis_reset) begin
      pkt_done      = 1'b0;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tuser  = '0;
      m_axis_tkeep  = '0;
      m_axis_tlast  = 1'b0;
      o_fifo_rd_en  = '0;
      o_grant       = '0;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state      <= S_IDLE;
      sel        <= '0;
      last_grant <= IW'(NUM_QUEUES - 1);
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      last_grant <= last_grant_nxt;
    end
  end

`ifdef PKT_ARB_CNT_EN
  logic [PKT_CNT_W-1:0] pkt_cnt [NUM_QUEUES];

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      for (int q = 0; q < NUM_QUEUES; q++) pkt_cnt[q] <= '0;
    end else if (pkt_done) begin
      pkt_cnt[sel] <= pkt_cnt[sel] + 1'b1;
    end
  end

  always_comb begin
    o_pkt_cnt = '0;
    for (int q = 0; q < NUM_QUEUES; q++) o_pkt_cnt[slice_lo(q, PKT_CNT_W) +: PKT_CNT_W] = pkt_cnt[q];
  end
`else
  logic unused_pkt_done;
  assign unused_pkt_done = pkt_done;
  assign o_pkt_cnt       = '0;
`endif

endmodule
